mux_nto1_pipe: RTL and testbench

Parametrised N-source, WIDTH-bit selector with one registered output stage and valid/ready handshakes on every source and on the output. Two modes: fixed select, driven by the pipeline control, or round-robin arbitration among valid sources. Used in the pipelined datapath where a plain combinational 4:1 select can no longer meet timing or must arbitrate shared resources (writeback port, memory request).

---
 rtl/mux_nto1_pipe.sv | 103 ++++++++++
 tb/tb_mux_nto1_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe.sv
// N-source registered selector with valid/ready handshakes; fixed-select or round-robin mode.
// Optional even-parity output out_par is built when MUX_PARITY_EN is defined.
module mux_nto1_pipe #(
    parameter  int WIDTH = 32,
    parameter  int NSRC  = 4,
    localparam int SELW  = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic                  flush,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_valid,
    output logic [NSRC-1:0]       src_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_src,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUX_PARITY_EN
    ,
    output logic                  out_par
`endif
);

    logic              load_en;
    logic [NSRC-1:0]   cand;
    logic [NSRC-1:0]   grant;
    logic              xfer;
    logic [SELW-1:0]   xfer_idx;
    logic [WIDTH-1:0]  xfer_data;
    logic [SELW-1:0]   rr_ptr;
    logic [SELW:0]     sum;
    logic [SELW-1:0]   idx;
    logic              found;

    always_comb begin
        load_en = (!out_valid || out_ready) && !flush;
        cand    = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        if (!mode) begin
            // out-of-range sel matches no bit, leaving cand empty
            for (int i = 0; i < NSRC; i++) begin
                if (sel == SELW'(i)) cand[i] = 1'b1;
            end
        end else begin
            // search starts one past the last granted source, wrapping at NSRC
            for (int k = 1; k <= NSRC; k++) begin
                sum = {1'b0, rr_ptr} + (SELW+1)'(k);
                if (sum >= (SELW+1)'(NSRC)) sum = sum - (SELW+1)'(NSRC);
                idx = sum[SELW-1:0];
                if (!found && src_valid[idx]) begin
                    cand      = '0;
                    cand[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    assign src_ready = load_en ? cand : '0;
    assign grant     = src_valid & src_ready;
    assign xfer      = |grant;

    always_comb begin
        xfer_idx  = '0;
        xfer_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                xfer_idx  = SELW'(i);
                xfer_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= SELW'(NSRC - 1);
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= xfer_data;
            out_src   <= xfer_idx;
            if (mode) rr_ptr <= xfer_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)    out_par <= 1'b0;
        else if (xfer) out_par <= ^xfer_data;
    end
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe: directed scenarios then random traffic against a reference model.
module tb_mux_nto1_pipe;
    localparam int WIDTH = 32;
    localparam int NSRC  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode = 1'b0;
    logic [1:0]       sel = '0;
    logic             flush = 1'b0;
    logic [127:0]     src_data = '0;
    logic [3:0]       src_valid = '0;
    logic [3:0]       src_ready;
    logic [31:0]      out_data;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef MUX_PARITY_EN
    logic             out_par;
`endif

    mux_nto1_pipe #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .flush(flush),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_PARITY_EN
        , .out_par(out_par)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit        m_valid = 0;
    bit [31:0] m_data  = 0;
    int        m_src   = 0;
    int        m_ptr   = NSRC - 1;
    bit        m_par   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [3:0] model_ready();
        if (flush || (m_valid && !out_ready)) return 4'b0;
        if (!mode) return 4'(1) << sel;
        for (int k = 1; k <= NSRC; k++) begin
            int i = (m_ptr + k) % NSRC;
            if (src_valid[i]) return 4'(1) << i;
        end
        return 4'b0;
    endfunction

    // one clock: check handshake, advance model at the edge, check registered outputs
    task automatic tick();
        bit [3:0] r;
        #1;
        r = model_ready();
        if (rst_n) chk("src_ready", {28'b0, src_ready}, {28'b0, r});
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = NSRC - 1; m_par = 0;
        end else if (flush) begin
            m_valid = 0;
        end else if ((r & src_valid) != 0) begin
            for (int i = 0; i < NSRC; i++) begin
                if (r[i] && src_valid[i]) begin
                    m_data  = src_data[i*32 +: 32];
                    m_src   = i;
                    m_valid = 1;
                    m_par   = ^m_data;
                    if (mode) m_ptr = i;
                end
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_data", out_data, m_data);
        chk("out_src", {30'b0, out_src}, 32'(m_src));
`ifdef MUX_PARITY_EN
        chk("out_par", {31'b0, out_par}, {31'b0, m_par});
`endif
        @(negedge clk);
    endtask

    function automatic logic [127:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int seq4 [5] = '{0, 1, 2, 3, 0};
    int seqrr[3] = '{3, 1, 3};
    logic [31:0] held_data;

    initial begin
        // reset
        rst_n = 0; src_data = rand_data(); src_valid = 4'hF; out_ready = 1;
        tick(); tick();
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_data", out_data, 32'd0);

        // fixed select of source 2
        rst_n = 1; mode = 0; sel = 2; src_valid = 4'b0100;
        src_data = rand_data(); src_data[64 +: 32] = 32'hA5A5_0002;
        #1 chk("fixed_ready", {28'b0, src_ready}, 32'b0100);
        tick();
        chk("fixed_data", out_data, 32'hA5A5_0002);
        chk("fixed_src", {30'b0, out_src}, 32'd2);

        // round-robin with all sources valid
        mode = 1; src_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            src_data = rand_data();
            tick();
            chk("rr_all_seq", {30'b0, out_src}, 32'(seq4[k]));
        end

        // stall with toggling sources
        out_ready = 0;
        held_data = out_data;
        for (int k = 0; k < 3; k++) begin
            src_data = rand_data(); src_valid = 4'($urandom);
            mode = 1'($urandom);
            tick();
            chk("stall_hold", out_data, held_data);
        end
        out_ready = 1; mode = 1; src_valid = 4'hF; src_data = rand_data();
        tick();
        chk("stall_release_valid", {31'b0, out_valid}, 32'd1);

        // drive rr_ptr to 1, then sources 1 and 3 alternate starting with 3
        src_valid = 4'b0010; tick();
        src_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            src_data = rand_data();
            tick();
            chk("rr_1010_seq", {30'b0, out_src}, 32'(seqrr[k]));
        end

        // flush beats out_ready; pointer unaffected
        flush = 1; src_valid = 4'b0001; tick();
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        flush = 0; src_valid = 4'hF; src_data = rand_data(); tick();
        chk("flush_ptr_kept", {30'b0, out_src}, 32'd0);

        // parity values, then reset during a stall
        mode = 0; sel = 1; src_valid = 4'b0010;
        src_data = rand_data(); src_data[32 +: 32] = 32'h0000_0007; tick();
`ifdef MUX_PARITY_EN
        chk("par_7", {31'b0, out_par}, 32'd1);
`endif
        src_data[32 +: 32] = 32'h0000_0003; tick();
`ifdef MUX_PARITY_EN
        chk("par_3", {31'b0, out_par}, 32'd0);
`endif
        out_ready = 0; tick();
        rst_n = 0; tick();
        chk("reset_stall_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1;

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(63) != 0);
            flush     = ($urandom_range(7) == 0);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            src_valid = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            src_data  = rand_data();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
